bq_coef_loader: RTL and testbench

BQ_COEF_LOADER -- requirements
Module: bq_coef_loader

---
 rtl/bq_coef_loader_if.sv | 21 ++
 rtl/bq_coef_loader.sv | 163 ++++++++++++++++
 tb/tb_bq_coef_loader.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bq_coef_loader_if.sv
// Wishbone master/slave bundle used by the biquad coefficient loader.
// Member names keep the master-side direction suffixes so both ends read alike.
interface bq_coef_loader_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [2:0]  adr_o;
    logic [15:0] dat_o;
    logic [15:0] dat_i;
    logic        ack_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o,
        output dat_i, ack_i
    );
endinterface

// File: rtl/bq_coef_loader.sv
// Loads five biquad coefficients into a Wishbone slave, optionally reads them back
// and compares, with a per-transfer ack timeout and sticky error reporting.
module bq_coef_loader #(
    parameter bit          VERIFY  = 1'b1,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     start,
    input  logic [15:0]              a11_i,
    input  logic [15:0]              a12_i,
    input  logic [15:0]              b10_i,
    input  logic [15:0]              b11_i,
    input  logic [15:0]              b12_i,
    bq_coef_loader_if.master         wb,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     tmo,
    output logic [2:0]               err_adr
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

    // Abort fires on the edge that would bring the wait count up to TIMEOUT.
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);
    localparam logic [2:0] IdxLast = 3'd4;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] coef_q [5];
    logic [15:0] coef_d [5];
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;
    logic [2:0]  err_adr_q, err_adr_d;

    logic        cyc, stb, we;
    logic [2:0]  adr;
    logic [15:0] dat;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        coef_d    = coef_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        err_adr_d = err_adr_q;
        cyc       = 1'b0;
        stb       = 1'b0;
        we        = 1'b0;
        adr       = 3'd0;
        dat       = 16'h0000;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    coef_d[0] = a11_i;
                    coef_d[1] = a12_i;
                    coef_d[2] = b10_i;
                    coef_d[3] = b11_i;
                    coef_d[4] = b12_i;
                    idx_d     = 3'd0;
                    wait_d    = 8'd0;
                    err_d     = 1'b0;
                    tmo_d     = 1'b0;
                    err_adr_d = 3'd0;
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                cyc = 1'b1;
                stb = 1'b1;
                we  = 1'b1;
                adr = idx_q;
                dat = coef_q[idx_q];
                if (wb.ack_i) begin
                    wait_d = 8'd0;
                    if (idx_q == IdxLast) begin
                        idx_d   = 3'd0;
                        state_d = VERIFY ? StRead : StDone;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StRead: begin
                cyc = 1'b1;
                stb = 1'b1;
                adr = idx_q;
                if (wb.ack_i) begin
                    wait_d = 8'd0;
                    // Only the first mismatching address is recorded.
                    if (wb.dat_i != coef_q[idx_q] && !err_q) begin
                        err_d     = 1'b1;
                        err_adr_d = idx_q;
                    end
                    if (idx_q == IdxLast) begin
                        idx_d   = 3'd0;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (stb && !wb.ack_i) begin
            if (wait_q == TmoLast) begin
                err_d = 1'b1;
                tmo_d = 1'b1;
                if (!err_q) begin
                    err_adr_d = idx_q;
                end
                idx_d   = 3'd0;
                wait_d  = 8'd0;
                state_d = StDone;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= StIdle;
            idx_q     <= 3'd0;
            wait_q    <= 8'd0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            err_adr_q <= 3'd0;
            for (int i = 0; i < 5; i++) begin
                coef_q[i] <= 16'h0000;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            err_adr_q <= err_adr_d;
            coef_q    <= coef_d;
        end
    end

    assign wb.cyc_o = cyc;
    assign wb.stb_o = stb;
    assign wb.we_o  = we;
    assign wb.adr_o = adr;
    assign wb.dat_o = dat;
    assign busy     = (state_q != StIdle);
    assign err      = err_q;
    assign tmo      = tmo_q;
    assign err_adr  = err_adr_q;

endmodule

// File: tb/tb_bq_coef_loader.sv
// Bench for bq_coef_loader: a verifying instance checked through a transfer scoreboard
// and a write-only instance checked for latency with and without wait states.
module tb_bq_coef_loader;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start0, start1;
    logic [15:0] cin [5];
    logic        busy0, done0, err0, tmo0;
    logic [2:0]  err_adr0;
    logic        busy1, done1, err1, tmo1;
    logic [2:0]  err_adr1;

    int n_tests = 0;
    int n_fail  = 0;

    bq_coef_loader_if wb0 ();
    bq_coef_loader_if wb1 ();

    bq_coef_loader u_dut0 (
        .clk(clk), .nreset(nreset), .start(start0),
        .a11_i(cin[0]), .a12_i(cin[1]), .b10_i(cin[2]), .b11_i(cin[3]), .b12_i(cin[4]),
        .wb(wb0), .busy(busy0), .done(done0), .err(err0), .tmo(tmo0), .err_adr(err_adr0)
    );

    bq_coef_loader #(.VERIFY(1'b0)) u_dut1 (
        .clk(clk), .nreset(nreset), .start(start1),
        .a11_i(cin[0]), .a12_i(cin[1]), .b10_i(cin[2]), .b11_i(cin[3]), .b12_i(cin[4]),
        .wb(wb1), .busy(busy1), .done(done1), .err(err1), .tmo(tmo1), .err_adr(err_adr1)
    );

    always #5 clk = ~clk;

    // Slave models: mode 0 = same-cycle ack, 1 = never ack, 2 = three wait states.
    logic [1:0]  mode0 = 2'd0, mode1 = 2'd0;
    logic [2:0]  ws0 = 3'd0, ws1 = 3'd0;
    logic [15:0] mem0 [5];
    logic [15:0] mem1 [5];
    logic [4:0]  cmask = 5'd0;
    logic [15:0] cval [5];
    logic [15:0] rd0;

    assign wb0.ack_i = (mode0 == 2'd0) ? wb0.stb_o :
                       (mode0 == 2'd2) ? (wb0.stb_o && ws0 == 3'd3) : 1'b0;
    assign wb1.ack_i = (mode1 == 2'd0) ? wb1.stb_o :
                       (mode1 == 2'd2) ? (wb1.stb_o && ws1 == 3'd3) : 1'b0;

    always_comb begin
        rd0 = 16'h0000;
        if (wb0.adr_o < 3'd5) begin
            rd0 = cmask[wb0.adr_o] ? cval[wb0.adr_o] : mem0[wb0.adr_o];
        end
    end
    assign wb0.dat_i = (wb0.stb_o && !wb0.we_o) ? rd0 : 16'h0000;
    assign wb1.dat_i = 16'h0000;

    always @(posedge clk) begin
        if (!wb0.stb_o || wb0.ack_i) ws0 <= 3'd0;
        else                         ws0 <= ws0 + 3'd1;
        if (wb0.stb_o && wb0.ack_i && wb0.we_o && wb0.adr_o < 3'd5) mem0[wb0.adr_o] <= wb0.dat_o;
        if (!wb1.stb_o || wb1.ack_i) ws1 <= 3'd0;
        else                         ws1 <= ws1 + 3'd1;
        if (wb1.stb_o && wb1.ack_i && wb1.we_o && wb1.adr_o < 3'd5) mem1[wb1.adr_o] <= wb1.dat_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard of expected transfers {we, adr, dat} on instance 0.
    typedef struct packed {
        logic        we;
        logic [2:0]  adr;
        logic [15:0] dat;
    } xfer_t;
    xfer_t exp_q[$];

    always @(negedge clk) begin
        if (nreset && wb0.stb_o && wb0.ack_i) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got we=%b adr=%0d dat=%h, expected no transfer",
                         wb0.we_o, wb0.adr_o, wb0.dat_o);
            end else begin
                check("sb_xfer", 32'({wb0.we_o, wb0.adr_o, wb0.dat_o}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [15:0] c [5]);
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, 3'(i), c[i]});
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 3'(i), 16'h0000});
    endtask

    function automatic logic [31:0] outs0();
        return 32'({wb0.cyc_o, wb0.stb_o, wb0.we_o, wb0.adr_o, wb0.dat_o,
                    busy0, done0, err0, tmo0, err_adr0});
    endfunction

    function automatic logic [31:0] outs1();
        return 32'({wb1.cyc_o, wb1.stb_o, wb1.we_o, wb1.adr_o, wb1.dat_o,
                    busy1, done1, err1, tmo1, err_adr1});
    endfunction

    typedef struct {
        logic [15:0] coef [5];
        logic [4:0]  cm;
        logic [15:0] cv [5];
        logic        exp_err;
        logic [2:0]  exp_adr;
    } vec_t;
    vec_t vecs [5];

    initial begin
        int n;
        int ndone;
        int done_at;
        logic [15:0] cur [5];

        vecs[0].coef = '{16'h4001, 16'hC000, 16'h2000, 16'h1000, 16'h0800};
        vecs[0].cm = 5'b00000; vecs[0].cv = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        vecs[0].exp_err = 1'b0; vecs[0].exp_adr = 3'd0;
        vecs[1].coef = '{16'h4001, 16'hC000, 16'h2000, 16'h1000, 16'h0800};
        vecs[1].cm = 5'b01100; vecs[1].cv = '{16'h0, 16'h0, 16'h2001, 16'h0000, 16'h0};
        vecs[1].exp_err = 1'b1; vecs[1].exp_adr = 3'd2;
        vecs[2].coef = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h0000};
        vecs[2].cm = 5'b10000; vecs[2].cv = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0001};
        vecs[2].exp_err = 1'b1; vecs[2].exp_adr = 3'd4;
        vecs[3].coef = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F};
        vecs[3].cm = 5'b10001; vecs[3].cv = '{16'h1235, 16'h0, 16'h0, 16'h0, 16'h0000};
        vecs[3].exp_err = 1'b1; vecs[3].exp_adr = 3'd0;
        vecs[4].coef = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        vecs[4].cm = 5'b00010; vecs[4].cv = '{16'h0, 16'h2222, 16'h0, 16'h0, 16'h0};
        vecs[4].exp_err = 1'b0; vecs[4].exp_adr = 3'd0;

        nreset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cin[i] = 16'h0000; cval[i] = 16'h0000; mem0[i] = 16'h0000; mem1[i] = 16'h0000;
        end

        #2 nreset = 1'b0;
        #1;
        check("reset_async_outs0", outs0(), 32'd0);
        check("reset_async_outs1", outs1(), 32'd0);
        tick; tick;
        nreset = 1'b1;
        tick;
        check("idle_outs0", outs0(), 32'd0);

        // Table-driven verify runs with same-cycle ack.
        for (int v = 0; v < 5; v++) begin
            cin   = vecs[v].coef;
            cmask = vecs[v].cm;
            cval  = vecs[v].cv;
            push_seq(vecs[v].coef);
            start0 = 1'b1;
            tick;
            start0 = 1'b0;
            check("first_write", 32'({wb0.cyc_o, wb0.stb_o, wb0.we_o, wb0.adr_o, busy0, err0}),
                  32'({3'b111, 3'd0, 1'b1, 1'b0}));
            for (int i = 0; i < 5; i++) cin[i] = ~vecs[v].coef[i];
            n = 0;
            while (!done0 && n < 60) begin
                tick;
                n++;
            end
            check("done_edge_v", 32'(n), 32'd10);
            check("done_status", 32'({busy0, done0, err0, tmo0, err_adr0}),
                  32'({1'b1, 1'b1, vecs[v].exp_err, 1'b0, vecs[v].exp_adr}));
            tick;
            check("after_done", 32'({busy0, done0, wb0.cyc_o, err0, err_adr0}),
                  32'({3'b000, vecs[v].exp_err, vecs[v].exp_adr}));
            check("sb_empty", 32'(exp_q.size()), 32'd0);
        end

        // Ack never arrives: abort after 15 strobed cycles at address 0.
        cmask = 5'd0;
        mode0 = 2'd1;
        cin   = vecs[0].coef;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        n = 0;
        while (wb0.stb_o && n < 100) begin
            if (wb0.adr_o != 3'd0) check("tmo_adr", 32'(wb0.adr_o), 32'd0);
            tick;
            n++;
        end
        check("tmo_stb_cycles", 32'(n), 32'd15);
        check("tmo_status", 32'({busy0, done0, err0, tmo0, err_adr0, wb0.cyc_o}),
              32'({4'b1111, 3'd0, 1'b0}));
        tick;
        check("tmo_idle", 32'({busy0, done0, err0, tmo0}), 32'({4'b0011}));

        // Second start mid-sequence is ignored; the accepted start clears err/tmo.
        mode0 = 2'd0;
        cur = vecs[3].coef;
        cin = cur;
        push_seq(cur);
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        check("start_clears_err", 32'({err0, tmo0}), 32'd0);
        ndone = 0;
        done_at = 0;
        for (int e = 1; e <= 20; e++) begin
            start0 = (e == 4);
            tick;
            if (done0) begin
                ndone++;
                done_at = e;
            end
        end
        start0 = 1'b0;
        check("restart_done_count", 32'(ndone), 32'd1);
        check("restart_done_edge", 32'(done_at), 32'd10);
        check("restart_err", 32'({busy0, err0, tmo0}), 32'd0);
        check("restart_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset during READ at index 2, with an error already latched from index 0.
        cmask = 5'b00001;
        cval[0] = 16'hDEAD;
        cur = vecs[0].coef;
        cin = cur;
        push_seq(cur);
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        for (int e = 0; e < 7; e++) tick;
        check("read_idx2", 32'({wb0.cyc_o, wb0.stb_o, wb0.we_o, wb0.adr_o, err0}),
              32'({3'b110, 3'd2, 1'b1}));
        #1 nreset = 1'b0;
        #1;
        check("midreset_outs0", outs0(), 32'd0);
        ndone = 0;
        for (int e = 0; e < 3; e++) begin
            tick;
            if (done0) ndone++;
        end
        #2 nreset = 1'b1;
        exp_q.delete();
        tick;
        if (done0) ndone++;
        check("midreset_no_done", 32'(ndone), 32'd0);
        check("midreset_idle", outs0(), 32'd0);
        cmask = 5'd0;

        // Write-only instance, same-cycle ack then three wait states.
        cin = vecs[2].coef;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 60) begin
            if (!wb1.we_o) check("v0_no_read", 32'(wb1.we_o), 32'd1);
            tick;
            n++;
        end
        check("v0_done_edge", 32'(n), 32'd5);
        check("v0_status", 32'({busy1, done1, err1, tmo1}), 32'({4'b1100}));
        tick;
        mode1 = 2'd2;
        cin = vecs[3].coef;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 60) begin
            tick;
            n++;
        end
        check("ws_done_edge", 32'(n), 32'd20);
        check("ws_status", 32'({err1, tmo1}), 32'd0);
        for (int i = 0; i < 5; i++) check("ws_mem", 32'(mem1[i]), 32'(vecs[3].coef[i]));
        tick;
        check("ws_idle", outs1(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
